// File: rtl/msi_pkg.sv
// Shared encodings for the MSI coherence controller: bus messages,
// per-line coherence states and request FSM states.
package msi_pkg;

    localparam int MSG_W = 3;
    localparam int LS_W  = 3;
    localparam int FSM_W = 3;

    localparam logic [MSG_W-1:0] MSG_IDLE  = 3'd0;
    localparam logic [MSG_W-1:0] MSG_RD    = 3'd1;
    localparam logic [MSG_W-1:0] MSG_RDX   = 3'd2;
    localparam logic [MSG_W-1:0] MSG_UPGR  = 3'd3;
    localparam logic [MSG_W-1:0] MSG_FLUSH = 3'd4;

    localparam logic [LS_W-1:0] LS_I  = 3'd0;
    localparam logic [LS_W-1:0] LS_IS = 3'd1;
    localparam logic [LS_W-1:0] LS_IM = 3'd2;
    localparam logic [LS_W-1:0] LS_S  = 3'd3;
    localparam logic [LS_W-1:0] LS_SM = 3'd4;
    localparam logic [LS_W-1:0] LS_M  = 3'd5;

    localparam logic [FSM_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [FSM_W-1:0] ST_ARB   = 3'd1;
    localparam logic [FSM_W-1:0] ST_ISSUE = 3'd2;
    localparam logic [FSM_W-1:0] ST_WAIT  = 3'd3;
    localparam logic [FSM_W-1:0] ST_DONE  = 3'd4;

    typedef logic [LS_W-1:0] line_state_t;

endpackage

// File: rtl/msi_line_next.sv
// Combinational next-state logic for one cache line. Snoop-driven changes
// win over processor-driven changes in the same cycle.
module msi_line_next
    import msi_pkg::*;
(
    input  logic [LS_W-1:0]  cur_state,
    input  logic             snoop_hit,
    input  logic [MSG_W-1:0] snoop_msg,
    input  logic             start_upgr,
    input  logic             issue,
    input  logic             issue_wr,
    input  logic             fill,
    output logic [LS_W-1:0]  next_state,
    output logic             flush
);

    line_state_t snoop_next;
    logic        snoop_act;

    // Transient IS/IM lines ignore snoops; FLUSH from others needs no action.
    always_comb begin
        snoop_next = cur_state;
        flush      = 1'b0;
        if (snoop_hit) begin
            case (snoop_msg)
                MSG_RD: begin
                    if (cur_state == LS_M) begin
                        snoop_next = LS_S;
                        flush      = 1'b1;
                    end
                end
                MSG_RDX, MSG_UPGR: begin
                    case (cur_state)
                        LS_M: begin
                            if (snoop_msg == MSG_RDX) begin
                                snoop_next = LS_I;
                                flush      = 1'b1;
                            end
                        end
                        LS_S:    snoop_next = LS_I;
                        LS_SM:   snoop_next = LS_IM;
                        default: snoop_next = cur_state;
                    endcase
                end
                MSG_IDLE, MSG_FLUSH: snoop_next = cur_state;
                default:             snoop_next = cur_state;
            endcase
        end
    end

    assign snoop_act = (snoop_next != cur_state);

    always_comb begin
        next_state = snoop_next;
        if (!snoop_act) begin
            if (start_upgr && cur_state == LS_S) begin
                next_state = LS_SM;
            end else if (issue) begin
                case (cur_state)
                    LS_I:    next_state = issue_wr ? LS_IM : LS_IS;
                    LS_SM:   next_state = LS_M;
                    default: next_state = cur_state;
                endcase
            end else if (fill) begin
                case (cur_state)
                    LS_IS:   next_state = LS_S;
                    LS_IM:   next_state = LS_M;
                    default: next_state = cur_state;
                endcase
            end
        end
    end

endmodule

// File: rtl/msi_cache_ctrl.sv
// MSI coherence controller for a private cache: request FSM, bus arbitration,
// snoop handling with flush, and per-line state registers.
module msi_cache_ctrl
    import msi_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = 2,
    parameter int CPU_ID    = 0,
    parameter int ID_W      = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pr_req_i,
    input  logic              pr_wr_i,
    input  logic [ADDR_W-1:0] pr_addr_i,
    output logic              pr_busy_o,
    output logic              pr_done_o,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic [2:0]        bus_msg_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [ID_W-1:0]   bus_src_o,
    input  logic [2:0]        bus_msg_i,
    input  logic [ADDR_W-1:0] bus_addr_i,
    input  logic [ID_W-1:0]   bus_src_i,
    input  logic              data_valid_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    output logic              flush_o,
    output logic [ADDR_W-1:0] flush_addr_o
);

    logic [FSM_W-1:0]     state_q;
    logic [FSM_W-1:0]     state_d;
    logic [ADDR_W-1:0]    pend_addr_q;
    logic                 pend_wr_q;
    line_state_t          line_q [NUM_LINES];
    line_state_t          line_d [NUM_LINES];
    logic [NUM_LINES-1:0] line_flush;
    logic                 flush_q;
    logic [ADDR_W-1:0]    flush_addr_q;

    logic        snoop_valid;
    logic        accept;
    logic        pr_hit;
    logic        fill_match;
    line_state_t pr_line;
    line_state_t pend_line;
    line_state_t pend_line_nxt;

    assign snoop_valid = (bus_msg_i != MSG_IDLE) && (bus_src_i != ID_W'(CPU_ID));
    assign accept      = (state_q == ST_IDLE) && pr_req_i;
    assign fill_match  = (state_q == ST_WAIT) && data_valid_i && (data_addr_i == pend_addr_q);

    // Address decode without out-of-range indexing when NUM_LINES < 2**ADDR_W.
    always_comb begin
        pr_line       = LS_I;
        pend_line     = LS_I;
        pend_line_nxt = LS_I;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (pr_addr_i == ADDR_W'(i)) begin
                pr_line = line_q[i];
            end
            if (pend_addr_q == ADDR_W'(i)) begin
                pend_line     = line_q[i];
                pend_line_nxt = line_d[i];
            end
        end
    end

    assign pr_hit = pr_wr_i ? (pr_line == LS_M) : (pr_line == LS_S || pr_line == LS_M);

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        logic sel_pr;
        logic sel_pend;
        logic snoop_hit;

        assign sel_pr    = (pr_addr_i == ADDR_W'(g));
        assign sel_pend  = (pend_addr_q == ADDR_W'(g));
        assign snoop_hit = snoop_valid && (bus_addr_i == ADDR_W'(g));

        msi_line_next u_line_next (
            .cur_state  (line_q[g]),
            .snoop_hit  (snoop_hit),
            .snoop_msg  (bus_msg_i),
            .start_upgr (accept && pr_wr_i && sel_pr),
            .issue      ((state_q == ST_ISSUE) && sel_pend),
            .issue_wr   (pend_wr_q),
            .fill       (fill_match && sel_pend),
            .next_state (line_d[g]),
            .flush      (line_flush[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                line_q[i] <= LS_I;
            end
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                line_q[i] <= line_d[i];
            end
        end
    end

    // A snoop may demote the pending line during ISSUE, which forces a WAIT for data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pr_req_i) state_d = pr_hit ? ST_DONE : ST_ARB;
            ST_ARB:   if (bus_gnt_i) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (pend_line_nxt == LS_IS || pend_line_nxt == LS_IM) ? ST_WAIT : ST_DONE;
            ST_WAIT:  if (fill_match) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            pend_addr_q  <= '0;
            pend_wr_q    <= 1'b0;
            flush_q      <= 1'b0;
            flush_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pend_addr_q <= pr_addr_i;
                pend_wr_q   <= pr_wr_i;
            end
            flush_q      <= |line_flush;
            flush_addr_q <= (|line_flush) ? bus_addr_i : '0;
        end
    end

    always_comb begin
        bus_msg_o = MSG_IDLE;
        if (state_q == ST_ISSUE) begin
            case (pend_line)
                LS_SM:   bus_msg_o = MSG_UPGR;
                LS_IM:   bus_msg_o = MSG_RDX;
                LS_I:    bus_msg_o = pend_wr_q ? MSG_RDX : MSG_RD;
                default: bus_msg_o = MSG_IDLE;
            endcase
        end
    end

    assign bus_addr_o   = (state_q == ST_ISSUE) ? pend_addr_q : '0;
    assign bus_req_o    = (state_q == ST_ARB);
    assign bus_src_o    = ID_W'(CPU_ID);
    assign pr_busy_o    = (state_q != ST_IDLE);
    assign pr_done_o    = (state_q == ST_DONE);
    assign flush_o      = flush_q;
    assign flush_addr_o = flush_addr_q;

endmodule
